// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions, resolved against EX outcomes.
// Produces predictor training strobes, mispredict/flush requests and saturating statistics.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_pc,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     upd_en,
  output logic                     upd_branch,
  output logic                     mispredict,
  output logic [PC_W-1:0]          mispredict_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt,
  output logic                     resolve_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic             upd_en_q, upd_en_d;
  logic             upd_branch_q, upd_branch_d;
  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  mispredict_pc_q, mispredict_pc_d;
  logic             resolve_err_q, resolve_err_d;

  logic             taken_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];

  logic             empty;
  logic             full;
  logic             head_taken;
  logic [PC_W-1:0]  head_pc;
  logic             do_resolve;
  logic             do_mis;
  logic             do_push;

  assign empty      = (occ_q == '0);
  assign full       = (occ_q == OccW'(DEPTH));
  assign pred_ready = ~full;

  assign head_taken = taken_mem[head_q];
  assign head_pc    = pc_mem[head_q];

  assign do_resolve = res_valid & ~empty;
  assign do_mis     = do_resolve & (res_taken != head_taken);
  // A mispredict flushes everything younger, including a same-cycle push.
  assign do_push    = pred_valid & pred_ready & ~do_mis;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (do_mis) begin
      head_d = tail_q;
      occ_d  = '0;
    end else begin
      if (do_resolve) begin
        head_d = head_q + PtrW'(1);
      end
      if (do_push) begin
        tail_d = tail_q + PtrW'(1);
      end
      unique case ({do_push, do_resolve})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_comb begin
    upd_en_d        = do_resolve;
    upd_branch_d    = do_resolve ? res_taken : upd_branch_q;
    mispredict_d    = do_mis;
    mispredict_pc_d = do_mis ? head_pc : mispredict_pc_q;
    resolve_err_d   = resolve_err_q | (res_valid & empty);
    bcnt_d          = bcnt_q;
    mcnt_d          = mcnt_q;
    if (do_resolve && (bcnt_q != '1)) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end
    if (do_mis && (mcnt_q != '1)) begin
      mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q          <= '0;
      tail_q          <= '0;
      occ_q           <= '0;
      bcnt_q          <= '0;
      mcnt_q          <= '0;
      upd_en_q        <= 1'b0;
      upd_branch_q    <= 1'b0;
      mispredict_q    <= 1'b0;
      mispredict_pc_q <= '0;
      resolve_err_q   <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      occ_q           <= occ_d;
      bcnt_q          <= bcnt_d;
      mcnt_q          <= mcnt_d;
      upd_en_q        <= upd_en_d;
      upd_branch_q    <= upd_branch_d;
      mispredict_q    <= mispredict_d;
      mispredict_pc_q <= mispredict_pc_d;
      resolve_err_q   <= resolve_err_d;
    end
  end

  // Entry payload needs no reset: it is only read while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      taken_mem[tail_q] <= pred_taken;
      pc_mem[tail_q]    <= pred_pc;
    end
  end

  assign upd_en        = upd_en_q;
  assign upd_branch    = upd_branch_q;
  assign mispredict    = mispredict_q;
  assign mispredict_pc = mispredict_pc_q;
  assign occupancy     = occ_q;
  assign branch_cnt    = bcnt_q;
  assign mispred_cnt   = mcnt_q;
  assign resolve_err   = resolve_err_q;

endmodule
